operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL provide parameter: N, default 2, the systolic array dimension; each matrix holds N*N 8-bit elements.
REQ-002 SHALL provide port: clk  input  1  the single clock; all state updates occur on the rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: start  input  1  single-cycle pulse that begins one load sequence.
REQ-005 SHALL provide port: inst_req  output  1  request for the instruction byte.
REQ-006 SHALL provide port: wght_req  output  1  request for a weight byte.
REQ-007 SHALL provide port: mtrx_req  output  1  request for a matrix byte.
REQ-008 SHALL provide port: data_ready  input  1  strobe from the memory controller: in_data is valid.
REQ-009 SHALL provide port: output_sel  input  2  source tag for in_data: 01 = wght, 10 = mtrx, 11 = inst.
REQ-010 SHALL provide port: in_data  input  8  byte delivered by the memory controller.
REQ-011 SHALL provide port: inst_out  output  8  captured instruction byte.
REQ-012 SHALL provide port: weights  output  8*N*N  weight matrix, row-major; element k occupies bits [8k+7:8k].
REQ-013 SHALL provide port: matrix  output  8*N*N  input matrix, row-major, same packing as weights.
REQ-014 SHALL provide port: busy  output  1  high while a sequence is in progress.
REQ-015 SHALL provide port: done  output  1  one-cycle pulse when the sequence completes.
REQ-016 SHALL provide port: err  output  1  sticky tag-mismatch flag.

Function
REQ-017 SHALL implement FSM states IDLE, INST, WGHT, MTRX and GAP; GAP records the state to return to.
REQ-018 SHALL transition IDLE->INST on start; start received in any other state SHALL be ignored.
REQ-019 SHALL, on accepting start, clear inst_out, weights, matrix, err and the element index idx to 0.
REQ-020 SHALL drive all requests from registers, so that start in cycle 0 gives inst_req=1 in cycle 1.
REQ-021 SHALL keep requests one-hot: inst_req only in INST, wght_req only in WGHT, mtrx_req only in MTRX, all low elsewhere.
REQ-022 SHALL accept a byte only when data_ready=1 and output_sel matches the current state's tag (INST=11, WGHT=01, MTRX=10).
REQ-023 SHALL, on accepting a byte, write in_data to inst_out (INST) or to element idx of weights/matrix, then enter GAP for exactly one cycle with all requests low.
REQ-024 SHALL, after GAP, re-enter the same state with idx+1, or advance: INST->WGHT (idx=0), WGHT after element N*N-1 -> MTRX (idx=0), MTRX after element N*N-1 -> IDLE.
REQ-025 SHALL size idx as clog2(N*N) bits; idx SHALL never exceed N*N-1.
REQ-026 SHALL assert done for exactly the one cycle in which the FSM returns to IDLE after the last matrix byte.
REQ-027 SHALL hold busy=1 from the cycle after start through the final GAP cycle, and busy=0 in the done cycle.
REQ-028 SHALL treat data_ready=1 with a non-matching output_sel in INST/WGHT/MTRX as a mismatch: no capture, request held, err set to 1.
REQ-029 SHALL hold err at 1 until reset or the next accepted start.
REQ-030 SHALL ignore data_ready in IDLE and GAP: no capture and no err.
REQ-031 SHALL hold inst_out, weights and matrix stable from done until the next accepted start.

Reset
REQ-032 SHALL, when rst=0, immediately (asynchronously) set state=IDLE, idx=0, all requests, busy, done and err to 0, and inst_out, weights and matrix to 0.
REQ-033 SHALL abandon a sequence interrupted by reset; the first rising clk edge with rst=1 SHALL evaluate from IDLE.

Verification
REQ-034 SHALL cover a full load (N=2): start, then inst 0xA5 and weights 01,02,03,04 and matrix 05,06,07,08, each answered one cycle after its request -> inst_out=A5, weights=0x04030201, matrix=0x08070605, one done pulse, err=0.
REQ-035 SHALL cover a mismatch: during WGHT, data_ready with output_sel=10 and in_data=0xFF -> no capture, wght_req stays 1, err=1, then a correct byte is accepted.
REQ-036 SHALL cover start during busy: a second start pulse while in MTRX -> ignored, and the original sequence completes unchanged.
REQ-037 SHALL cover reset mid-operation: rst=0 while in WGHT with idx=2 -> all outputs 0 before the next clock edge, and a subsequent start loads cleanly.
REQ-038 SHALL cover stray strobes: data_ready=1 during IDLE and during GAP -> no capture, err=0, idx unchanged.
REQ-039 SHALL cover request timing: a delayed response with data_ready arriving 5 cycles after wght_req -> wght_req held high all 5 cycles, and exactly one GAP cycle follows.

Source files
------------

// File: rtl/operand_loader.sv
// Fetches one instruction byte, N*N weight bytes and N*N matrix bytes from a memory
// controller, with a one-cycle GAP after every accepted byte and a sticky tag-mismatch flag.
module operand_loader #(
   parameter int N = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               inst_req,
   output logic               wght_req,
   output logic               mtrx_req,
   input  logic               data_ready,
   input  logic [1:0]         output_sel,
   input  logic [7:0]         in_data,
   output logic [7:0]         inst_out,
   output logic [8*N*N-1:0]   weights,
   output logic [8*N*N-1:0]   matrix,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int IDX_W = (N * N > 1) ? $clog2(N * N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

   typedef enum logic [2:0] {IDLE, INST, WGHT, MTRX, GAP} state_t;

   state_t             state_q, state_d;
   state_t             ret_q, ret_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               inst_req_q, inst_req_d;
   logic               wght_req_q, wght_req_d;
   logic               mtrx_req_q, mtrx_req_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [7:0]         inst_out_q, inst_out_d;
   logic [8*N*N-1:0]   weights_q, weights_d;
   logic [8*N*N-1:0]   matrix_q, matrix_d;
   logic [1:0]         cur_tag;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ret_q      <= IDLE;
         idx_q      <= '0;
         inst_req_q <= 1'b0;
         wght_req_q <= 1'b0;
         mtrx_req_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         inst_out_q <= '0;
         weights_q  <= '0;
         matrix_q   <= '0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         idx_q      <= idx_d;
         inst_req_q <= inst_req_d;
         wght_req_q <= wght_req_d;
         mtrx_req_q <= mtrx_req_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         inst_out_q <= inst_out_d;
         weights_q  <= weights_d;
         matrix_q   <= matrix_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      idx_d      = idx_q;
      err_d      = err_q;
      done_d     = 1'b0;
      inst_out_d = inst_out_q;
      weights_d  = weights_q;
      matrix_d   = matrix_q;
      cur_tag    = 2'b00;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = INST;
               idx_d      = '0;
               err_d      = 1'b0;
               inst_out_d = '0;
               weights_d  = '0;
               matrix_d   = '0;
            end
         end
         INST, WGHT, MTRX: begin
            case (state_q)
               INST:    cur_tag = 2'b11;
               WGHT:    cur_tag = 2'b01;
               default: cur_tag = 2'b10;
            endcase
            if (data_ready) begin
               if (output_sel == cur_tag) begin
                  case (state_q)
                     INST:    inst_out_d = in_data;
                     WGHT:    weights_d[{idx_q, 3'b000} +: 8] = in_data;
                     default: matrix_d[{idx_q, 3'b000} +: 8] = in_data;
                  endcase
                  ret_d   = state_q;
                  state_d = GAP;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         GAP: begin
            // Leaving GAP either repeats the phase at the next element or moves on.
            case (ret_q)
               INST: begin
                  state_d = WGHT;
                  idx_d   = '0;
               end
               WGHT: begin
                  if (idx_q == LAST_IDX) begin
                     state_d = MTRX;
                     idx_d   = '0;
                  end else begin
                     state_d = WGHT;
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end
               MTRX: begin
                  if (idx_q == LAST_IDX) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = MTRX;
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end
               default: state_d = IDLE;
            endcase
         end
         default: state_d = IDLE;
      endcase

      // Requests and busy are registered copies of the next state.
      inst_req_d = (state_d == INST);
      wght_req_d = (state_d == WGHT);
      mtrx_req_d = (state_d == MTRX);
      busy_d     = (state_d != IDLE);
   end

   assign inst_req = inst_req_q;
   assign wght_req = wght_req_q;
   assign mtrx_req = mtrx_req_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign inst_out = inst_out_q;
   assign weights  = weights_q;
   assign matrix   = matrix_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader (N=2): full loads, tag mismatch,
// ignored start, mid-sequence reset, stray strobes and a delayed response.
module tb_operand_loader;

   localparam int N = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             data_ready = 1'b0;
   logic [1:0]       output_sel = 2'b00;
   logic [7:0]       in_data = 8'h00;
   logic             inst_req, wght_req, mtrx_req;
   logic [7:0]       inst_out;
   logic [8*N*N-1:0] weights, matrix;
   logic             busy, done, err;

   int compared = 0;
   int mismatched = 0;

   operand_loader #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start),
      .inst_req(inst_req), .wght_req(wght_req), .mtrx_req(mtrx_req),
      .data_ready(data_ready), .output_sel(output_sel), .in_data(in_data),
      .inst_out(inst_out), .weights(weights), .matrix(matrix),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Watchdog so a stuck handshake can never hang the run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts and reports any difference
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic reqFor(input logic [1:0] sel);
      case (sel)
         2'b11:   return inst_req;
         2'b01:   return wght_req;
         2'b10:   return mtrx_req;
         default: return 1'b0;
      endcase
   endfunction

   task automatic pulseStart;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Waits for the request matching sel, delays the answer, delivers one byte and
   // walks through the GAP cycle (optionally firing a stray strobe inside it)
   task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] data, input int delay, input bit gapStrobe);
      int waited = 0;
      while (!reqFor(sel) && waited < 20) begin
         tick();
         waited++;
      end
      checkOutput("reqSeen", reqFor(sel), 1);
      for (int i = 0; i < delay; i++) begin
         tick();
         checkOutput("reqHeld", reqFor(sel), 1);
      end
      data_ready = 1'b1;
      output_sel = sel;
      in_data    = data;
      tick();
      data_ready = 1'b0;
      checkOutput("gapReqs", {inst_req, wght_req, mtrx_req}, 0);
      checkOutput("gapBusy", busy, 1);
      if (gapStrobe) begin
         data_ready = 1'b1;
         output_sel = sel;
         in_data    = 8'hEE;
      end
      tick();
      data_ready = 1'b0;
   endtask

   task automatic loadSequence(input logic [7:0] inst, input logic [31:0] w, input logic [31:0] m, input int delay);
      applyStimulus(2'b11, inst, delay, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(2'b01, w[8*k +: 8], delay, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(2'b10, m[8*k +: 8], delay, 1'b0);
   endtask

   initial begin
      // Asynchronous reset with no clock edge involved
      #2 rst = 1'b0;
      #1;
      checkOutput("rstReqs", {inst_req, wght_req, mtrx_req}, 0);
      checkOutput("rstFlags", {busy, done, err}, 0);
      checkOutput("rstInst", inst_out, 0);
      checkOutput("rstWeights", weights, 0);
      checkOutput("rstMatrix", matrix, 0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Stray strobe while idle
      data_ready = 1'b1; output_sel = 2'b11; in_data = 8'h77;
      tick(); tick();
      data_ready = 1'b0;
      checkOutput("idleStrayInst", inst_out, 0);
      checkOutput("idleStrayErr", err, 0);
      checkOutput("idleStrayBusy", {busy, inst_req}, 0);

      // Full load, each byte answered one cycle after its request
      pulseStart();
      checkOutput("startReq", {inst_req, wght_req, mtrx_req}, 3'b100);
      checkOutput("startBusy", busy, 1);
      loadSequence(8'hA5, 32'h04030201, 32'h08070605, 1);
      checkOutput("s1Done", {done, busy}, 2'b10);
      checkOutput("s1Inst", inst_out, 8'hA5);
      checkOutput("s1Weights", weights, 32'h04030201);
      checkOutput("s1Matrix", matrix, 32'h08070605);
      checkOutput("s1Err", err, 0);
      tick();
      checkOutput("s1DoneOnce", done, 0);
      tick(); tick();
      checkOutput("s1HoldInst", inst_out, 8'hA5);
      checkOutput("s1HoldWeights", weights, 32'h04030201);
      checkOutput("s1HoldMatrix", matrix, 32'h08070605);

      // Mismatch, stray strobes in GAP and an ignored start while in MTRX
      pulseStart();
      checkOutput("s2ClearW", weights, 0);
      checkOutput("s2ClearM", matrix, 0);
      checkOutput("s2ClearI", inst_out, 0);
      applyStimulus(2'b11, 8'h3C, 0, 1'b1);
      checkOutput("s2Inst", inst_out, 8'h3C);
      checkOutput("s2WghtReq", wght_req, 1);
      checkOutput("s2GapErr", err, 0);
      data_ready = 1'b1; output_sel = 2'b10; in_data = 8'hFF;
      tick();
      data_ready = 1'b0;
      checkOutput("mismatchReq", wght_req, 1);
      checkOutput("mismatchErr", err, 1);
      checkOutput("mismatchW", weights, 0);
      checkOutput("mismatchM", matrix, 0);
      applyStimulus(2'b01, 8'h11, 0, 1'b1);
      checkOutput("afterMismatchW", weights, 32'h00000011);
      applyStimulus(2'b01, 8'h22, 1, 1'b0);
      applyStimulus(2'b01, 8'h33, 0, 1'b0);
      applyStimulus(2'b01, 8'h44, 0, 1'b0);
      checkOutput("s2Weights", weights, 32'h44332211);
      applyStimulus(2'b10, 8'h55, 0, 1'b0);
      pulseStart();
      checkOutput("busyStartReq", {inst_req, wght_req, mtrx_req}, 3'b001);
      checkOutput("busyStartErr", err, 1);
      checkOutput("busyStartM", matrix, 32'h00000055);
      applyStimulus(2'b10, 8'h66, 0, 1'b0);
      applyStimulus(2'b10, 8'h77, 0, 1'b0);
      applyStimulus(2'b10, 8'h88, 0, 1'b0);
      checkOutput("s2Done", {done, busy}, 2'b10);
      checkOutput("s2Matrix", matrix, 32'h88776655);
      checkOutput("s2Weights2", weights, 32'h44332211);
      checkOutput("s2Inst2", inst_out, 8'h3C);
      checkOutput("s2ErrSticky", err, 1);
      tick();

      // Reset in the middle of the weight phase at element 2
      pulseStart();
      checkOutput("s3ErrCleared", err, 0);
      applyStimulus(2'b11, 8'hC3, 0, 1'b0);
      applyStimulus(2'b01, 8'h9A, 0, 1'b0);
      applyStimulus(2'b01, 8'h9B, 0, 1'b0);
      checkOutput("s3WghtIdx2", wght_req, 1);
      #1 rst = 1'b0;
      #1;
      checkOutput("midRstReqs", {inst_req, wght_req, mtrx_req}, 0);
      checkOutput("midRstFlags", {busy, done, err}, 0);
      checkOutput("midRstInst", inst_out, 0);
      checkOutput("midRstWeights", weights, 0);
      checkOutput("midRstMatrix", matrix, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      checkOutput("postRstIdle", {busy, inst_req, wght_req}, 0);

      // Clean load after reset with one weight answered five cycles late
      pulseStart();
      applyStimulus(2'b11, 8'hDE, 0, 1'b0);
      applyStimulus(2'b01, 8'h10, 0, 1'b0);
      applyStimulus(2'b01, 8'h20, 5, 1'b0);
      checkOutput("singleGap", wght_req, 1);
      applyStimulus(2'b01, 8'h30, 0, 1'b0);
      applyStimulus(2'b01, 8'h40, 0, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(2'b10, 8'h50 + 8'(16 * k), 0, 1'b0);
      checkOutput("s4Done", {done, busy}, 2'b10);
      checkOutput("s4Inst", inst_out, 8'hDE);
      checkOutput("s4Weights", weights, 32'h40302010);
      checkOutput("s4Matrix", matrix, 32'h80706050);
      checkOutput("s4Err", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
